// File: rtl/spi_loader_pkg.sv
// Shared types and default widths for the serial memory loader.
package spi_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_IMEM = 2'b01,
        MODE_DMEM = 2'b10,
        MODE_RUN  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_WAIT,
        ST_LOADED,
        ST_RUN
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Input conditioning for the loader: optional 2-flop synchronizers
// (SPI_LOADER_SYNC_EN) followed by sclk rising-edge detect.
module spi_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       mosi_in,
    input  logic [1:0] mode_in,
    output logic       rise_o,
    output logic       mosi_o,
    output logic [1:0] mode_o
);

    logic sclk_s;
    logic sclk_q;

`ifdef SPI_LOADER_SYNC_EN
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] mode_s1_q;
    logic [1:0] mode_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            mode_s1_q   <= '0;
            mode_s2_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_in};
            mosi_sync_q <= {mosi_sync_q[0], mosi_in};
            mode_s1_q   <= mode_in;
            mode_s2_q   <= mode_s1_q;
        end
    end

    assign sclk_s = sclk_sync_q[1];
    assign mosi_o = mosi_sync_q[1];
    assign mode_o = mode_s2_q;
`else
    assign sclk_s = sclk_in;
    assign mosi_o = mosi_in;
    assign mode_o = mode_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sclk_q <= 1'b0;
        else        sclk_q <= sclk_s;
    end

    assign rise_o = sclk_s & ~sclk_q;

endmodule

// File: rtl/spi_loader.sv
// Serial memory loader: deserialises LSB-first {data, addr} frames into
// imem/dmem write strobes and owns the load/run hand-over. Optional input
// synchronizers are enabled with SPI_LOADER_SYNC_EN (see spi_edge_sync).
//   state   | meaning
//   IDLE    | waiting for a load or run mode
//   SHIFT   | collecting frame bits on sclk rises
//   COMMIT  | one-cycle write strobe to the latched memory
//   WAIT    | frame written, waiting for mode to return to idle
//   LOADED  | last address written, done_out high
//   RUN     | core enabled, done_out follows halt_in
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic [1:0]        mode_in,
    input  logic              halt_in,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              run_out,
    output logic              done_out,
    output logic              frame_err
);

    localparam int FRAME_BITS = ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    logic       rise;
    logic       mosi_s;
    logic [1:0] mode_s;
    mode_t      mode_cur;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d, shift_next;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mode_t                   mode_lat_q, mode_lat_d;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;

    spi_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk_in (sclk_in),
        .mosi_in (mosi_in),
        .mode_in (mode_in),
        .rise_o  (rise),
        .mosi_o  (mosi_s),
        .mode_o  (mode_s)
    );

    assign mode_cur = mode_t'(mode_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            mode_lat_q <= MODE_IDLE;
            err_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        err_d      = err_q;
        addr_d     = addr_q;
        data_d     = data_q;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        run_out    = 1'b0;
        done_out   = 1'b0;
        shift_next = {mosi_s, shift_q[FRAME_BITS-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (mode_cur == MODE_IMEM || mode_cur == MODE_DMEM) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    mode_lat_d = mode_cur;
                end else if (mode_cur == MODE_RUN) begin
                    state_d = ST_RUN;
                end
            end
            ST_SHIFT: begin
                // A mode change outranks a coincident rise: the bit is dropped.
                if (mode_cur != mode_lat_q) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rise) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = ST_COMMIT;
                        addr_d  = shift_next[ADDR_W-1:0];
                        data_d  = shift_next[FRAME_BITS-1:ADDR_W];
                    end
                end
            end
            ST_COMMIT: begin
                imem_we = (mode_lat_q == MODE_IMEM);
                dmem_we = (mode_lat_q == MODE_DMEM);
                state_d = (addr_q == '1) ? ST_LOADED : ST_WAIT;
            end
            ST_WAIT: begin
                if (mode_cur == MODE_IDLE) begin
                    state_d = ST_IDLE;
                end else if (mode_cur != mode_lat_q) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_LOADED: begin
                done_out = 1'b1;
                if (mode_cur != mode_lat_q) state_d = ST_IDLE;
            end
            ST_RUN: begin
                run_out  = 1'b1;
                done_out = halt_in;
                if (mode_cur != MODE_RUN) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign frame_err = err_q;

endmodule
